mem_wbuf_ctrl: RTL and testbench

MEM_WBUF_CTRL -- requirements
Module: mem_wbuf_ctrl

---
 rtl/mem_wbuf_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_wbuf_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wbuf_ctrl.sv
// mem_wbuf_ctrl
//   Store buffer in front of a synchronous single-port RAM. Processor stores
//   are queued in a small FIFO and drained to the RAM when no load needs the
//   RAM port. Loads are first looked up in the buffer. A hit returns the
//   newest buffered data one edge after the request. A miss reads the RAM
//   through a two-state issue/capture sequence.
//
// Ports
//   Clock     : sole clock, rising edge
//   Resetn    : asynchronous active-low reset
//   addrM     : processor load/store address (low AW bits used)
//   doutM     : processor store data
//   wM        : store strobe
//   rdReq     : load request (honoured only when the controller is idle)
//   mem       : registered load data
//   rdValid   : one-cycle pulse qualifying mem
//   busy      : buffer full or RAM read in flight
//   overflow  : sticky, a store was dropped because the buffer was full
//   ram_addr  : registered RAM address
//   ram_din   : registered RAM write data
//   ram_we    : registered RAM write enable
//   ram_dout  : RAM read data, one edge after ram_addr is sampled
module mem_wbuf_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic [15:0]   addrM,
    input  logic [15:0]   doutM,
    input  logic          wM,
    input  logic          rdReq,
    output logic [15:0]   mem,
    output logic          rdValid,
    output logic          busy,
    output logic          overflow,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    output logic          ram_we,
    input  logic [15:0]   ram_dout
);

    localparam int DATA_W = 16;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Buffer storage is plain data and is never reset; head/tail/count
    // define which slots hold valid entries.
    logic [AW-1:0]     buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;

    logic              full;
    logic              rd_start;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PW-1:0]     idx;
    logic              hit;
    logic              miss;

    assign full     = (count == CW'(DEPTH));
    assign rd_start = (state == IDLE) && rdReq;
    assign pop      = (state == IDLE) && !rdReq && (count != '0);
    // A pop at the same edge frees the slot being written, so a full
    // buffer can still accept a store while it drains.
    assign push     = wM && (!full || pop);
    assign drop     = wM && full && !pop;
    assign hit      = rd_start && fwd_hit;
    assign miss     = rd_start && !fwd_hit;
    assign busy     = full || (state != IDLE);

    // Scan from oldest to newest so the last match wins, giving the newest
    // store to that address. Only entries present before this edge are seen.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (buf_addr[idx] == addrM[AW-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[idx];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (miss) state_nxt = RD_ISSUE;
            RD_ISSUE: state_nxt = RD_CAPT;
            RD_CAPT:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            mem      <= '0;
            rdValid  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (drop) overflow <= 1'b1;

            rdValid <= 1'b0;
            ram_we  <= 1'b0;
            if (hit) begin
                mem     <= fwd_data;
                rdValid <= 1'b1;
            end else if (miss) begin
                ram_addr <= addrM[AW-1:0];
            end else if (pop) begin
                ram_addr <= buf_addr[head];
                ram_din  <= buf_data[head];
                ram_we   <= 1'b1;
            end

            // RAM data became valid at the previous edge (RD_ISSUE).
            if (state == RD_CAPT) begin
                mem     <= ram_dout;
                rdValid <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            buf_addr[tail] <= addrM[AW-1:0];
            buf_data[tail] <= doutM;
        end
    end

    generate
        if (AW < 16) begin : g_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^addrM[15:AW];
        end
    endgenerate

endmodule

// File: tb/tb_mem_wbuf_ctrl.sv
// Testbench for mem_wbuf_ctrl: directed stimulus with a scoreboard of
// expected load returns and expected RAM writes, plus a small RAM model.
module tb_mem_wbuf_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b1;
    logic [15:0]   addrM  = '0;
    logic [15:0]   doutM  = '0;
    logic          wM     = 1'b0;
    logic          rdReq  = 1'b0;
    logic [15:0]   mem;
    logic          rdValid;
    logic          busy;
    logic          overflow;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic          ram_we;
    logic [15:0]   ram_dout;

    int checks = 0;
    int errors = 0;

    logic [15:0]      exp_rd_q [$];
    logic [AW+15:0]   exp_wr_q [$];
    logic [15:0]      mon_rd;
    logic [AW+15:0]   mon_wr;
    logic [15:0]      ram [256];

    mem_wbuf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .addrM    (addrM),
        .doutM    (doutM),
        .wM       (wM),
        .rdReq    (rdReq),
        .mem      (mem),
        .rdValid  (rdValid),
        .busy     (busy),
        .overflow (overflow),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM model, read-before-write, owned by a single process.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h10] = 16'h5A5A;
        ram[8'h20] = 16'hCAFE;
        ram[8'h50] = 16'h5050;
        ram[8'h53] = 16'h5353;
        ram[8'h60] = 16'h6060;
        ram[8'h63] = 16'h6363;
        ram[8'h71] = 16'h7171;
        ram_dout <= 16'h0000;
        forever begin
            @(posedge Clock);
            ram_dout <= ram[ram_addr];
            if (ram_we === 1'b1) ram[ram_addr] = ram_din;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge Clock) begin
        if (Resetn === 1'b1) begin
            if (rdValid !== 1'b0) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra mem=%h rdValid=%b required no rdValid", mem, rdValid);
                end else begin
                    mon_rd = exp_rd_q.pop_front();
                    if (mem !== mon_rd) begin
                        errors++;
                        $display("FAIL rd_data got=%h required=%h", mem, mon_rd);
                    end
                end
            end
            if (ram_we !== 1'b0) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra addr=%h din=%h required no ram_we", ram_addr, ram_din);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    if ({ram_addr, ram_din} !== mon_wr) begin
                        errors++;
                        $display("FAIL wr_data got=%h required=%h", {ram_addr, ram_din}, mon_wr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        addrM = '0;
        doutM = '0;
        wM    = 1'b0;
        rdReq = 1'b0;
    endtask

    task automatic st(input logic [15:0] a, input logic [15:0] d);
        addrM = a;
        doutM = d;
        wM    = 1'b1;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending_rd=%0d pending_wr=%0d required 0", exp_rd_q.size(), exp_wr_q.size());
        end
        cyc();
        cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem"},      32'(mem),      32'h0);
        chk({tag, "_rdValid"},  32'(rdValid),  32'h0);
        chk({tag, "_busy"},     32'(busy),     32'h0);
        chk({tag, "_overflow"}, 32'(overflow), 32'h0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, "_ram_din"},  32'(ram_din),  32'h0);
        chk({tag, "_ram_we"},   32'(ram_we),   32'h0);
    endtask

    initial begin
        idle();
        #2 Resetn = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) @(posedge Clock);
        #3 Resetn = 1'b1;

        // Store then drain
        st(16'h0005, 16'h1234);
        exp_wr_q.push_back({8'h05, 16'h1234});
        cyc();
        idle();
        chk("t1_no_we_on_push", 32'(ram_we), 32'h0);
        cyc();
        chk("t1_we",   32'(ram_we),   32'h1);
        chk("t1_addr", 32'(ram_addr), 32'h05);
        chk("t1_din",  32'(ram_din),  32'h1234);
        cyc();
        chk("t1_we_one_cycle", 32'(ram_we), 32'h0);
        addrM = 16'h0005;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h1234);
        cyc();
        idle();
        wait_empty(10);

        // Forward hit, stores held by an in-flight read
        st(16'h0003, 16'hAAAA);
        exp_wr_q.push_back({8'h03, 16'hAAAA});
        cyc();
        wM    = 1'b0;
        addrM = 16'h0010;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h5A5A);
        cyc();
        chk("t2_busy_issue", 32'(busy), 32'h1);
        st(16'h0003, 16'hBBBB);
        rdReq = 1'b1;
        exp_wr_q.push_back({8'h03, 16'hBBBB});
        cyc();
        chk("t2_read_ignored", 32'(rdValid), 32'h0);
        idle();
        cyc();
        addrM = 16'h0003;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'hBBBB);
        cyc();
        idle();
        chk("t2_hit_valid", 32'(rdValid), 32'h1);
        chk("t2_hit_data",  32'(mem),     32'hBBBB);
        chk("t2_hit_busy",  32'(busy),    32'h0);
        wait_empty(20);

        // Miss read
        addrM = 16'h0020;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'hCAFE);
        cyc();
        idle();
        chk("t3_ram_addr", 32'(ram_addr), 32'h20);
        chk("t3_ram_we",   32'(ram_we),   32'h0);
        chk("t3_busy1",    32'(busy),     32'h1);
        chk("t3_nvalid1",  32'(rdValid),  32'h0);
        cyc();
        chk("t3_busy2",    32'(busy),     32'h1);
        chk("t3_nvalid2",  32'(rdValid),  32'h0);
        cyc();
        chk("t3_valid",    32'(rdValid),  32'h1);
        chk("t3_data",     32'(mem),      32'hCAFE);
        chk("t3_busy3",    32'(busy),     32'h0);
        cyc();
        chk("t3_pulse",    32'(rdValid),  32'h0);

        // Full buffer with simultaneous push and pop
        st(16'h0060, 16'hE0E0);
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h6060);
        exp_wr_q.push_back({8'h60, 16'hE0E0});
        cyc();
        rdReq = 1'b0;
        st(16'h0061, 16'hE1E1);
        exp_wr_q.push_back({8'h61, 16'hE1E1});
        cyc();
        st(16'h0062, 16'hE2E2);
        exp_wr_q.push_back({8'h62, 16'hE2E2});
        cyc();
        st(16'h0063, 16'hE3E3);
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h6363);
        exp_wr_q.push_back({8'h63, 16'hE3E3});
        cyc();
        chk("t6_busy_full", 32'(busy), 32'h1);
        idle();
        cyc();
        cyc();
        chk("t6_busy_idle_full", 32'(busy),     32'h1);
        chk("t6_no_overflow",    32'(overflow), 32'h0);
        st(16'h0064, 16'hE4E4);
        exp_wr_q.push_back({8'h64, 16'hE4E4});
        cyc();
        idle();
        chk("t6_busy_after_swap", 32'(busy),     32'h1);
        chk("t6_overflow_clear",  32'(overflow), 32'h0);
        chk("t6_drain_we",        32'(ram_we),   32'h1);
        chk("t6_drain_addr",      32'(ram_addr), 32'h60);
        wait_empty(30);

        // Overflow: five stores on consecutive edges, rdReq held
        st(16'h0050, 16'hD000);
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h5050);
        exp_wr_q.push_back({8'h50, 16'hD000});
        cyc();
        st(16'h0051, 16'hD001);
        exp_wr_q.push_back({8'h51, 16'hD001});
        cyc();
        st(16'h0052, 16'hD002);
        exp_wr_q.push_back({8'h52, 16'hD002});
        cyc();
        chk("t4_not_full", 32'(busy), 32'h0);
        st(16'h0053, 16'hD003);
        exp_rd_q.push_back(16'h5353);
        exp_wr_q.push_back({8'h53, 16'hD003});
        cyc();
        chk("t4_busy_full",   32'(busy),     32'h1);
        chk("t4_no_ovf_yet",  32'(overflow), 32'h0);
        st(16'h0054, 16'hD004);
        cyc();
        idle();
        chk("t4_overflow",    32'(overflow), 32'h1);
        cyc();
        wait_empty(30);
        chk("t4_ovf_sticky",  32'(overflow), 32'h1);
        addrM = 16'h0054;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h0000);
        cyc();
        idle();
        wait_empty(10);

        // Read/store collision
        st(16'h0007, 16'h1111);
        exp_wr_q.push_back({8'h07, 16'h1111});
        cyc();
        st(16'h0007, 16'h2222);
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h1111);
        exp_wr_q.push_back({8'h07, 16'h2222});
        cyc();
        chk("t5_old_value", 32'(mem), 32'h1111);
        wM    = 1'b0;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h2222);
        cyc();
        idle();
        chk("t5_new_value", 32'(mem), 32'h2222);
        wait_empty(20);

        // Reset in the middle of a read
        st(16'h0070, 16'h7777);
        cyc();
        wM    = 1'b0;
        addrM = 16'h0071;
        rdReq = 1'b1;
        cyc();
        idle();
        chk("t7_busy_pre",     32'(busy),     32'h1);
        chk("t7_ram_addr_pre", 32'(ram_addr), 32'h71);
        #1 Resetn = 1'b0;
        #1 chk_all_zero("t7_async");
        cyc();
        #2 Resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t7_no_valid", 32'(rdValid), 32'h0);
            chk("t7_no_we",    32'(ram_we),  32'h0);
        end
        chk("t7_busy_after", 32'(busy), 32'h0);
        addrM = 16'h0070;
        rdReq = 1'b1;
        exp_rd_q.push_back(16'h0000);
        cyc();
        idle();
        wait_empty(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
